// File: rtl/registro_pc.sv
// Program-counter state register: captures the next-PC on every rising edge,
// with a synchronous active-high reset that loads the boot address.
module registro_pc #(
  parameter int unsigned            WIDTH       = 32,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inputPC,
  output logic [WIDTH-1:0] outputPC
);

  // No enable: the PC advances on every edge, reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      outputPC <= RESET_VALUE;
    end else begin
      outputPC <= inputPC;
    end
  end

endmodule

// File: tb/tb_registro_pc.sv
// Directed bench for registro_pc: reset, load latency, last-value capture,
// hold between edges, same-timestep input change, full width and boot override.
module tb_registro_pc;

  localparam int unsigned WIDTH = 32;
  localparam logic [WIDTH-1:0] BOOT_ALT = 32'h0000_8000;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] input_pc;
  logic [WIDTH-1:0] output_pc;
  logic [WIDTH-1:0] output_pc_alt;

  int checks;
  int errors;

  registro_pc #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .inputPC  (input_pc),
    .outputPC (output_pc)
  );

  registro_pc #(.WIDTH(WIDTH), .RESET_VALUE(BOOT_ALT)) dut_alt (
    .clk      (clk),
    .rst      (rst),
    .inputPC  (input_pc),
    .outputPC (output_pc_alt)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    input_pc = 32'd56;

    // reset wins over inputPC
    tick();
    check_value("reset_default", output_pc, 32'h0);
    check_value("reset_override", output_pc_alt, BOOT_ALT);
    rst = 1'b0;
    tick();
    check_value("first_load", output_pc, 32'd56);
    check_value("first_load_alt", output_pc_alt, 32'd56);

    // basic load with mid-cycle change
    input_pc = 32'd0;
    tick();
    check_value("load_zero", output_pc, 32'd0);
    #2 input_pc = 32'd56;
    #1 check_value("mid_cycle_hold", output_pc, 32'd0);
    tick();
    check_value("load_56", output_pc, 32'd56);

    // only the value present at the rising edge is captured
    input_pc = 32'd79;
    @(negedge clk);
    #1;
    check_value("negedge_no_effect", output_pc, 32'd56);
    input_pc = 32'd23;
    tick();
    check_value("last_value", output_pc, 32'd23);

    // hold across falling edge and between-edge input changes
    @(negedge clk);
    #1;
    check_value("hold_negedge", output_pc, 32'd23);
    input_pc = 32'd5;
    #1 check_value("hold_input_change", output_pc, 32'd23);
    input_pc = 32'd23;
    tick();
    check_value("hold_reload", output_pc, 32'd23);

    // change scheduled in the same timestep as the edge
    @(posedge clk);
    input_pc <= 32'd896;
    #1 check_value("same_step_old", output_pc, 32'd23);
    tick();
    check_value("same_step_new", output_pc, 32'd896);

    // full width pass-through, including low bits
    input_pc = 32'hFFFF_FFFF;
    tick();
    check_value("all_ones", output_pc, 32'hFFFF_FFFF);
    input_pc = 32'h0000_0001;
    tick();
    check_value("one", output_pc, 32'h0000_0001);
    input_pc = 32'h1234_5677;
    tick();
    check_value("unaligned", output_pc, 32'h1234_5677);

    // reset mid-operation then resume
    rst      = 1'b1;
    input_pc = 32'h0000_ABCD;
    tick();
    check_value("mid_reset", output_pc, 32'h0);
    check_value("mid_reset_alt", output_pc_alt, BOOT_ALT);
    rst = 1'b0;
    tick();
    check_value("resume", output_pc, 32'h0000_ABCD);
    check_value("resume_alt", output_pc_alt, 32'h0000_ABCD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
